// File: rtl/fetch_stage.sv
// IF stage: fetches instr at pc_in over imem req/ack, loads IF/ID register; optional HALT_DETECT_EN.
// Latency: 1 ISSUE cycle + WAIT until ack; ID loads at the ack edge (1 instr per 2 cycles, zero-wait).
// Backpressure: stall holds ID and parks an acked word in the skid reg; flush squashes ID and the fetch in flight.
module fetch_stage #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int PC_STEP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               flush,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr_q;
    logic               r_drop;
    logic               w_drop_nxt;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               w_load;
    logic               w_capture;
    logic [INSTR_W-1:0] w_load_instr;
    logic               w_halt_blk;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_id_instr;
    logic [ADDR_W-1:0]  r_id_pc;
    logic [ADDR_W-1:0]  r_id_pc_next;

    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_load_instr = r_skid_instr;
        imem_req     = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                if (!w_halt_blk) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (r_drop || flush) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_ISSUE;
                    end else if (!stall) begin
                        w_load       = 1'b1;
                        w_load_instr = imem_data;
                        w_state_nxt  = ST_ISSUE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end else if (flush) begin
                    // Request cannot be withdrawn; remember to throw its data away.
                    w_drop_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (flush) begin
                    w_state_nxt = ST_ISSUE;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: begin
                w_state_nxt = ST_ISSUE;
            end
        endcase
    end

    // r_addr_q is frozen through WAIT/HELD, so it doubles as the skid PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ISSUE;
            r_addr_q     <= '0;
            r_drop       <= 1'b0;
            r_skid_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (r_state == ST_ISSUE && !w_halt_blk) begin
                r_addr_q <= pc_in;
            end
            if (w_capture) begin
                r_skid_instr <= imem_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
            r_id_pc      <= '0;
            r_id_pc_next <= '0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
        end else if (w_load) begin
            r_id_valid   <= 1'b1;
            r_id_instr   <= w_load_instr;
            r_id_pc      <= r_addr_q;
            r_id_pc_next <= r_addr_q + STEP;
        end else if (!stall) begin
            r_id_valid <= 1'b0;
        end
    end

`ifdef HALT_DETECT_EN
    logic r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (flush) begin
            r_halted <= 1'b0;
        end else if (w_load && (w_load_instr[INSTR_W-1 -: 4] == 4'hF)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halt_blk = r_halted;
    assign halted     = r_halted;
`else
    assign w_halt_blk = 1'b0;
    assign halted     = 1'b0;
`endif

    assign pc_advance = w_load;
    assign imem_addr  = r_addr_q;
    assign id_valid   = r_id_valid;
    assign id_instr   = r_id_instr;
    assign id_pc      = r_id_pc;
    assign id_pc_next = r_id_pc_next;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, PC-unit model and ID scoreboard run in the background.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_in = 16'h0000;
    logic        pc_advance;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_next;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_next;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mem_auto = 1'b0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic [15:0] halt_addr = 16'h0001;
    bit          chk_pend = 1'b0;

    fetch_stage #(.ADDR_W(16), .INSTR_W(16), .PC_STEP(2)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_advance(pc_advance),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_data(imem_data), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_next(id_pc_next), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == halt_addr) return 16'hF000;
        return {1'b0, a[4:2], a[11:0]} ^ 16'h0A5A;
    endfunction

    function automatic exp_t mk(input logic [15:0] pc);
        exp_t e;
        e.instr   = mem_word(pc);
        e.pc      = pc;
        e.pc_next = pc + 16'd2;
        return e;
    endfunction

    // Instruction memory: ack after mem_lat extra request cycles.
    initial forever begin
        @(negedge clk);
        if (!mem_auto) begin
            wait_cnt = 0;
        end else if (imem_req === 1'b1) begin
            if (wait_cnt >= mem_lat) begin
                imem_ack  = 1'b1;
                imem_data = mem_word(imem_addr);
                wait_cnt  = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // PC unit: steps by 2 on every accepted instruction.
    initial forever begin
        @(negedge clk);
        #1;
        if (pc_advance === 1'b1) begin
            @(posedge clk);
            #1;
            pc_in = pc_in + 16'd2;
        end
    end

    // Scoreboard: the cycle after each pc_advance the ID register must hold the next expected entry.
    initial forever begin
        exp_t e;
        @(negedge clk);
        #1;
        if (chk_pend) begin
            chk_pend = 1'b0;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_load: got pc=%h instr=%h, no load expected", id_pc, id_instr);
            end else begin
                e = sb.pop_front();
                if ({id_valid, id_instr, id_pc, id_pc_next} !== {1'b1, e}) begin
                    n_bad++;
                    $display("FAIL sb_id_reg: got v=%b instr=%h pc=%h next=%h, want v=1 instr=%h pc=%h next=%h",
                             id_valid, id_instr, id_pc, id_pc_next, e.instr, e.pc, e.pc_next);
                end
            end
        end
        if (pc_advance === 1'b1) chk_pend = 1'b1;
    end

    task automatic mem_stop;
        mem_auto = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic test_reset;
        logic [67:0] obs;
        repeat (2) @(negedge clk);
        #1;
        obs = {pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted};
        n_cmp++;
        if (obs !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_issue_noreq: got req=%b, want 0", imem_req);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait;
        int   adv[$];
        logic prev_adv;
        prev_adv = 1'b0;
        sb.push_back(mk(16'h0000));
        sb.push_back(mk(16'h0002));
        sb.push_back(mk(16'h0004));
        mem_lat  = 0;
        mem_auto = 1'b1;
        for (int c = 0; c < 40 && adv.size() < 3; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (id_valid !== prev_adv) begin
                n_bad++;
                $display("FAIL zw_id_valid: cycle %0d got %b, want %b", c, id_valid, prev_adv);
            end
            if (pc_advance === 1'b1) begin
                adv.push_back(c);
                n_cmp++;
                if (imem_ack !== 1'b1) begin
                    n_bad++;
                    $display("FAIL zw_adv_no_ack: got ack=%b, want 1", imem_ack);
                end
            end
            prev_adv = pc_advance;
        end
        n_cmp++;
        if (adv.size() != 3) begin
            n_bad++;
            $display("FAIL zw_timeout: got %0d loads, want 3", adv.size());
        end else if (adv[1] - adv[0] != 2 || adv[2] - adv[1] != 2) begin
            n_bad++;
            $display("FAIL zw_rate: got gaps %0d,%0d, want 2,2", adv[1] - adv[0], adv[2] - adv[1]);
        end
        mem_stop();
    endtask

    task automatic test_wait_states;
        int          adv[$];
        bit          in_req;
        logic [15:0] a0;
        logic [15:0] exp_addr;
        in_req = 1'b0;
        a0     = 16'h0000;
        sb.push_back(mk(16'h0006));
        sb.push_back(mk(16'h0008));
        mem_lat  = 3;
        mem_auto = 1'b1;
        for (int c = 0; c < 60 && adv.size() < 2; c++) begin
            @(negedge clk);
            #1;
            exp_addr = 16'h0006 + 16'(2 * adv.size());
            if (in_req) begin
                n_cmp++;
                if (imem_req !== 1'b1 || imem_addr !== a0) begin
                    n_bad++;
                    $display("FAIL ws_req_hold: got req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, a0);
                end
            end else if (imem_req === 1'b1) begin
                a0 = imem_addr;
                n_cmp++;
                if (imem_addr !== exp_addr) begin
                    n_bad++;
                    $display("FAIL ws_addr: got %h, want %h", imem_addr, exp_addr);
                end
            end
            in_req = (imem_req === 1'b1) && (imem_ack !== 1'b1);
            if (pc_advance === 1'b1) begin
                adv.push_back(c);
                n_cmp++;
                if (imem_ack !== 1'b1) begin
                    n_bad++;
                    $display("FAIL ws_adv_no_ack: got ack=%b, want 1", imem_ack);
                end
            end
        end
        n_cmp++;
        if (adv.size() != 2) begin
            n_bad++;
            $display("FAIL ws_timeout: got %0d loads, want 2", adv.size());
        end else if (adv[1] - adv[0] != 5) begin
            n_bad++;
            $display("FAIL ws_rate: got gap %0d, want 5", adv[1] - adv[0]);
        end
        mem_stop();
    endtask

    task automatic test_stall;
        bit got;
        got = 1'b0;
        sb.push_back(mk(16'h000A));
        sb.push_back(mk(16'h000C));
        mem_lat  = 0;
        mem_auto = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL st_timeout: got no load, want load of 000a");
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stall = 1'b1;
            if (k == 2) imem_ack = 1'b0;
            #1;
            n_cmp++;
            if (id_valid !== 1'b1 || id_pc !== 16'h000A || id_instr !== mem_word(16'h000A)) begin
                n_bad++;
                $display("FAIL st_id_hold: k=%0d got v=%b pc=%h instr=%h, want v=1 pc=000a instr=%h",
                         k, id_valid, id_pc, id_instr, mem_word(16'h000A));
            end
            n_cmp++;
            if (pc_advance !== 1'b0) begin
                n_bad++;
                $display("FAIL st_no_adv: k=%0d got %b, want 0", k, pc_advance);
            end
            if (k >= 2) begin
                n_cmp++;
                if (imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL st_held_noreq: k=%0d got %b, want 0", k, imem_req);
                end
            end
            if (k == 1) mem_auto = 1'b0;
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        n_cmp++;
        if (pc_advance !== 1'b1) begin
            n_bad++;
            $display("FAIL st_release_load: got %b, want 1", pc_advance);
        end
    endtask

    task automatic test_flush;
        bit got;
        got = 1'b0;
        sb.push_back(mk(16'h000E));
        sb.push_back(mk(16'h0040));
        mem_lat  = 0;
        mem_auto = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) got = 1'b1;
        end
        mem_lat = 2;
        @(negedge clk);
        #1;
        @(negedge clk);
        flush = 1'b1;
        pc_in = 16'h0040;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
            n_bad++;
            $display("FAIL fl_wait_addr: got req=%b addr=%h, want req=1 addr=0010", imem_req, imem_addr);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (id_valid !== 1'b0 || id_instr !== 16'h0000 || pc_advance !== 1'b0) begin
            n_bad++;
            $display("FAIL fl_id_squash: got v=%b instr=%h adv=%b, want 0 0000 0", id_valid, id_instr, pc_advance);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (pc_advance !== 1'b0) begin
            n_bad++;
            $display("FAIL fl_drop_ack: got adv=%b with ack=%b, want adv=0", pc_advance, imem_ack);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || pc_advance !== 1'b0) begin
            n_bad++;
            $display("FAIL fl_reissue: got req=%b adv=%b, want 0 0", imem_req, pc_advance);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            n_bad++;
            $display("FAIL fl_new_addr: got req=%b addr=%h, want req=1 addr=0040", imem_req, imem_addr);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fl_timeout: got no load, want load of 0040");
        end
        mem_stop();
    endtask

    task automatic test_reset_midfetch;
        logic [67:0] obs;
        @(negedge clk);
        #1;
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_pending: got req=%b, want 1", imem_req);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs = {pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted};
        n_cmp++;
        if (obs !== 68'h0) begin
            n_bad++;
            $display("FAIL rm_outputs: got %h, want 0", obs);
        end
        @(negedge clk);
        rst       = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hF123;
        #1;
        n_cmp++;
        if (pc_advance !== 1'b0 || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_late_ack: got adv=%b req=%b, want 0 0", pc_advance, imem_req);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0042 || id_valid !== 1'b0 || pc_advance !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_fresh_issue: got req=%b addr=%h v=%b adv=%b, want 1 0042 0 0",
                     imem_req, imem_addr, id_valid, pc_advance);
        end
    endtask

    task automatic test_wrap;
        bit got;
        got = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        pc_in = 16'hFFFE;
        sb.push_back(mk(16'hFFFE));
        mem_lat = 0;
        #1;
        mem_auto = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (pc_advance !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_drop: got adv=%b, want 0", pc_advance);
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) got = 1'b1;
        end
        mem_stop();
        #1;
        n_cmp++;
        if (!got || id_pc !== 16'hFFFE || id_pc_next !== 16'h0000) begin
            n_bad++;
            $display("FAIL wr_pc_next: got loaded=%b pc=%h next=%h, want 1 fffe 0000", got, id_pc, id_pc_next);
        end
    endtask

    task automatic test_halt;
        int adv[$];
        halt_addr = 16'h0000;
        sb.push_back(mk(16'h0000));
        sb.push_back(mk(16'h0002));
        mem_lat  = 0;
        mem_auto = 1'b1;
`ifdef HALT_DETECT_EN
        for (int c = 0; c < 20 && adv.size() < 1; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) adv.push_back(c);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc_advance !== 1'b0) begin
                n_bad++;
                $display("FAIL ht_halted: k=%0d got halted=%b req=%b adv=%b, want 1 0 0", k, halted, imem_req, pc_advance);
            end
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++;
            $display("FAIL ht_flush_clear: got halted=%b, want 0", halted);
        end
        for (int c = 0; c < 20 && adv.size() < 2; c++) begin
            @(negedge clk);
            #1;
            if (pc_advance === 1'b1) adv.push_back(c);
        end
        n_cmp++;
        if (adv.size() != 2) begin
            n_bad++;
            $display("FAIL ht_resume: got %0d loads, want 2", adv.size());
        end
`else
        for (int c = 0; c < 30 && adv.size() < 2; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (halted !== 1'b0) begin
                n_bad++;
                $display("FAIL nh_halted: got %b, want 0", halted);
            end
            if (pc_advance === 1'b1) adv.push_back(c);
        end
        n_cmp++;
        if (adv.size() != 2) begin
            n_bad++;
            $display("FAIL nh_timeout: got %0d loads, want 2", adv.size());
        end else if (adv[1] - adv[0] != 2) begin
            n_bad++;
            $display("FAIL nh_rate: got gap %0d, want 2", adv[1] - adv[0]);
        end
`endif
        mem_stop();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_flush();
        test_reset_midfetch();
        test_wrap();
        test_halt();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got %0d unconsumed entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
